sr_instr_encoder: RTL and testbench

//  Writer-side counterpart of the schoolRISCV decode stage: takes instruction fields over a

---
 rtl/sr_instr_encoder.sv | 217 +++++++++++++++++++++
 tb/tb_sr_instr_encoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_instr_encoder.sv
// sr_instr_encoder
//  Program loader for the shared instruction memory. Accepts instruction field
//  bundles over a valid/ready stream, encodes each one into an RV32I word and
//  writes it through a registered write port at consecutive word addresses.
//
// Ports
//  clk, rst_n        clock (rising edge), synchronous active-low reset
//  start             one-cycle pulse: open a new load session
//  in_valid/in_ready bundle handshake; a transfer is in_valid & in_ready
//  in_fmt..in_last   instruction fields, format select and end-of-program flag
//  imem_we/addr/wdata  registered instruction-memory write port
//  word_count        words written in the current session
//  done              session closed
//  err, err_code     sticky error flag and first error (1 fmt, 2 imm, 3 overflow)
module sr_instr_encoder #(
    parameter int unsigned       ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_f3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_f7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_FMT  = 2'd1;
    localparam logic [1:0] ERR_IMM  = 2'd2;
    localparam logic [1:0] ERR_OVF  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nx;
    logic [CNT_W-1:0]  cnt_nx;
    logic              ready_nx;
    logic              we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [31:0]       wdata_nx;
    logic              done_nx;
    logic              err_nx;
    logic [1:0]        code_nx;

    // Session view after an optional start in this cycle
    logic [ADDR_W-1:0] sess_ptr;
    logic [CNT_W-1:0]  sess_cnt;

    logic              xfer;
    logic [31:0]       enc_word;
    logic              fmt_ok;
    logic              imm_ok;
    logic              fits12;
    logic              fits13;
    logic              fits21;

    assign xfer = in_valid & in_ready;

    // Signed-range checks: upper bits must all equal the sign bit
    assign fits12 = (in_imm[31:11] == '0) | (&in_imm[31:11]);
    assign fits13 = (in_imm[31:12] == '0) | (&in_imm[31:12]);
    assign fits21 = (in_imm[31:20] == '0) | (&in_imm[31:20]);

    // Field packing per instruction format, plus immediate legality
    always_comb begin
        enc_word = '0;
        fmt_ok   = 1'b1;
        imm_ok   = 1'b1;
        case (in_fmt)
            FMT_R: enc_word = {in_f7, in_rs2, in_rs1, in_f3, in_rd, in_op};
            FMT_I: begin
                enc_word = {in_imm[11:0], in_rs1, in_f3, in_rd, in_op};
                imm_ok   = fits12;
            end
            FMT_S: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], in_op};
                imm_ok   = fits12;
            end
            FMT_B: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3,
                            in_imm[4:1], in_imm[11], in_op};
                imm_ok   = fits13 & ~in_imm[0];
            end
            FMT_U: begin
                enc_word = {in_imm[31:12], in_rd, in_op};
                imm_ok   = (in_imm[11:0] == '0);
            end
            FMT_J: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
                imm_ok   = fits21 & ~in_imm[0];
            end
            default: fmt_ok = 1'b0;
        endcase
    end

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= BASE_ADDR;
            word_count <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            word_count <= cnt_nx;
            in_ready   <= ready_nx;
            imem_we    <= we_nx;
            imem_addr  <= addr_nx;
            imem_wdata <= wdata_nx;
            done       <= done_nx;
            err        <= err_nx;
            err_code   <= code_nx;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nx = state;
        sess_ptr = ptr;
        sess_cnt = word_count;
        err_nx   = err;
        code_nx  = err_code;
        we_nx    = 1'b0;
        addr_nx  = imem_addr;
        wdata_nx = imem_wdata;

        // start opens a fresh session from any state; a bundle accepted in the
        // same cycle becomes the first word of that new session
        if (start) begin
            state_nx = ST_LOAD;
            sess_ptr = BASE_ADDR;
            sess_cnt = '0;
            err_nx   = 1'b0;
            code_nx  = ERR_NONE;
        end

        ptr_nx = sess_ptr;
        cnt_nx = sess_cnt;

        if (xfer) begin
            if (!fmt_ok) begin
                // Illegal format: bundle is consumed but nothing is written
                err_nx = 1'b1;
                if (code_nx == ERR_NONE) begin
                    code_nx = ERR_FMT;
                end
                if (in_last) begin
                    state_nx = ST_DONE;
                end
            end else begin
                we_nx    = 1'b1;
                addr_nx  = sess_ptr;
                wdata_nx = enc_word;
                ptr_nx   = sess_ptr + ADDR_W'(1);
                cnt_nx   = sess_cnt + CNT_W'(1);
                if (!imm_ok) begin
                    err_nx = 1'b1;
                    if (code_nx == ERR_NONE) begin
                        code_nx = ERR_IMM;
                    end
                end
                if (in_last) begin
                    state_nx = ST_DONE;
                end else if (sess_cnt == CNT_W'(DEPTH - 1)) begin
                    // Last free slot taken with more program to come
                    state_nx = ST_DONE;
                    err_nx   = 1'b1;
                    if (code_nx == ERR_NONE) begin
                        code_nx = ERR_OVF;
                    end
                end
            end
        end

        ready_nx = (state_nx == ST_LOAD) & ~cnt_nx[ADDR_W];
        done_nx  = (state_nx == ST_DONE);
    end

endmodule

// File: tb/tb_sr_instr_encoder.sv
// tb_sr_instr_encoder
//  Directed bench for sr_instr_encoder (ADDR_W=2, BASE_ADDR=1). A behavioural
//  loader model tracks expected outputs; a compare process checks every cycle,
//  and literal encodings pin the model.
module tb_sr_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int BASE  = 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_fmt;
    logic [6:0]    in_op;
    logic [4:0]    in_rd;
    logic [2:0]    in_f3;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [6:0]    in_f7;
    logic [31:0]   in_imm;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    sr_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(2'd1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_rd(in_rd), .in_f3(in_f3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_f7(in_f7), .in_imm(in_imm),
        .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .done(done), .err(err), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from shifted/masked fields
    function automatic logic [31:0] m_encode(input logic [2:0] fmt, input logic [6:0] op,
                                             input logic [4:0] rd, input logic [2:0] f3,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] regs;
        regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (fmt)
            3'd0: return regs | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
            3'd1: return regs | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
            3'd2: return regs | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20)
                              | ((imm & 32'h1F) << 7);
            3'd3: return regs | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                              | (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8)
                              | (((imm >> 11) & 32'h1) << 7);
            3'd4: return (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            default: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                            | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                            | (32'(rd) << 7) | 32'(op);
        endcase
    endfunction

    function automatic bit m_imm_ok(input logic [2:0] fmt, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (fmt)
            3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
            3'd3:       return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
            3'd4:       return (imm & 32'hFFF) == 32'h0;
            3'd5:       return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
            default:    return 1'b1;
        endcase
    endfunction

    // Behavioural loader model
    bit          m_loading, m_done, m_err, m_we, m_ready, m_xfer;
    int          m_cnt, m_addr;
    logic [1:0]  m_code;
    logic [31:0] m_wdata;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_loading = 0; m_done = 0; m_err = 0; m_we = 0; m_ready = 0;
            m_cnt = 0; m_code = 2'd0;
        end else begin
            m_xfer = in_valid && m_ready;
            m_we   = 0;
            if (start) begin
                m_loading = 1; m_done = 0; m_cnt = 0; m_err = 0; m_code = 2'd0;
            end
            if (m_xfer) begin
                if (in_fmt > 3'd5) begin
                    m_err = 1;
                    if (m_code == 2'd0) m_code = 2'd1;
                    if (in_last) begin m_loading = 0; m_done = 1; end
                end else begin
                    m_we    = 1;
                    m_addr  = (BASE + m_cnt) % DEPTH;
                    m_wdata = m_encode(in_fmt, in_op, in_rd, in_f3, in_rs1, in_rs2, in_f7, in_imm);
                    m_cnt   = m_cnt + 1;
                    if (!m_imm_ok(in_fmt, in_imm)) begin
                        m_err = 1;
                        if (m_code == 2'd0) m_code = 2'd2;
                    end
                    if (in_last) begin
                        m_loading = 0; m_done = 1;
                    end else if (m_cnt == DEPTH) begin
                        m_loading = 0; m_done = 1; m_err = 1;
                        if (m_code == 2'd0) m_code = 2'd3;
                    end
                end
            end
            m_ready = m_loading && (m_cnt < DEPTH);
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("imem_we", 32'(imem_we), 32'(m_we));
            if (m_we) begin
                chk("imem_addr", 32'(imem_addr), 32'(m_addr));
                chk("imem_wdata", imem_wdata, m_wdata);
            end
            chk("word_count", 32'(word_count), 32'(m_cnt));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("err_code", 32'(err_code), 32'(m_code));
        end
    end

    // Entered and left on a falling edge; consecutive calls stream back-to-back
    task automatic send(input int fmt, input int op, input int rd, input int f3,
                        input int rs1, input int rs2, input int f7, input int imm,
                        input bit last);
        int n;
        in_fmt = 3'(fmt); in_op = 7'(op); in_rd = 5'(rd); in_f3 = 3'(f3);
        in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_f7 = 7'(f7); in_imm = imm;
        in_last = last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake: in_ready stayed 0, expected 1 at %0t", $time);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_fmt = '0; in_op = '0; in_rd = '0; in_f3 = '0;
        in_rs1 = '0; in_rs2 = '0; in_f7 = '0; in_imm = '0;
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst imem_we", 32'(imem_we), 32'd0);
        chk("rst imem_addr", 32'(imem_addr), 32'(BASE));
        chk("rst imem_wdata", imem_wdata, 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic R/I/B program ending with in_last
        pulse_start();
        send(0, 'h33, 3, 0, 1, 2, 0, 0, 0);
        chk("add we", 32'(imem_we), 32'd1);
        chk("add word", imem_wdata, 32'h002081B3);
        chk("add addr", 32'(imem_addr), 32'(BASE));
        send(1, 'h13, 5, 0, 0, 0, 0, -1, 0);
        chk("addi word", imem_wdata, 32'hFFF00293);
        send(3, 'h63, 0, 0, 1, 2, 0, -4, 1);
        chk("beq word", imem_wdata, 32'hFE208EE3);
        chk("session1 done", 32'(done), 32'd1);
        chk("session1 err", 32'(err), 32'd0);
        @(negedge clk);

        // J/U, imm-range error, then illegal fmt keeps first code
        pulse_start();
        send(5, 'h6F, 1, 0, 0, 0, 0, 2048, 0);
        chk("jal word", imem_wdata, 32'h001000EF);
        send(4, 'h37, 7, 0, 0, 0, 0, 'h12345000, 0);
        chk("lui word", imem_wdata, 32'h123453B7);
        send(1, 'h13, 5, 0, 0, 0, 0, 2048, 0);
        chk("imm2048 word", imem_wdata, 32'h80000293);
        chk("imm2048 code", 32'(err_code), 32'd2);
        send(6, 'h13, 1, 0, 0, 0, 0, 0, 0);
        chk("fmt6 no write", 32'(imem_we), 32'd0);
        chk("fmt6 keeps code", 32'(err_code), 32'd2);
        send(2, 'h23, 0, 2, 1, 2, 0, 100, 1);
        @(negedge clk);

        // Final slot carries in_last: closes cleanly
        pulse_start();
        send(0, 'h33, 1, 0, 2, 3, 'h20, 0, 0);
        send(1, 'h13, 2, 0, 1, 0, 0, -2048, 0);
        send(2, 'h23, 0, 2, 4, 5, 0, 2047, 0);
        send(3, 'h63, 0, 1, 6, 7, 0, 4094, 1);
        chk("full last done", 32'(done), 32'd1);
        chk("full last err", 32'(err), 32'd0);
        chk("full last count", 32'(word_count), 32'd4);
        @(negedge clk);

        // Overflow: five bundles, no in_last
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send(1, 'h13, i + 1, 0, 0, 0, 0, i * 3, 0);
        end
        chk("ovf code", 32'(err_code), 32'd3);
        chk("ovf ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("ovf count", 32'(word_count), 32'd4);
        chk("ovf done", 32'(done), 32'd1);

        // Illegal fmt carrying in_last still closes the session
        pulse_start();
        send(7, 'h13, 1, 0, 0, 0, 0, 0, 1);
        chk("fmt7 done", 32'(done), 32'd1);
        chk("fmt7 code", 32'(err_code), 32'd1);
        chk("fmt7 count", 32'(word_count), 32'd0);
        @(negedge clk);

        // Restart while loading: pending write finishes, pointer rewinds
        pulse_start();
        send(0, 'h33, 3, 0, 1, 2, 0, 0, 0);
        send(0, 'h33, 4, 0, 1, 2, 0, 0, 0);
        pulse_start();
        send(1, 'h13, 9, 0, 0, 0, 0, 5, 0);
        chk("restart addr", 32'(imem_addr), 32'(BASE));
        chk("restart count", 32'(word_count), 32'd1);

        // Start coinciding with a transfer, then range violations
        start = 1'b1;
        send(3, 'h63, 0, 0, 1, 2, 0, 3, 0);
        start = 1'b0;
        chk("start+xfer addr", 32'(imem_addr), 32'(BASE));
        send(5, 'h6F, 1, 0, 0, 0, 0, 1048576, 0);
        send(4, 'h37, 2, 0, 0, 0, 0, 'h12345123, 1);
        @(negedge clk);

        // Reset during a transfer discards the write
        pulse_start();
        in_fmt = 3'd0; in_op = 7'h33; in_valid = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst drop we", 32'(imem_we), 32'd0);
        chk("rst drop count", 32'(word_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send(1, 'h13, 6, 0, 0, 0, 0, -7, 1);
        chk("post rst addr", 32'(imem_addr), 32'(BASE));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
